vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 23 ++
 rtl/mouse_frame_sync.sv | 68 ++++++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the display blocks: default 1024x768 timing,
// counter/position widths and the timing generator state type.
package vga_pkg;

  localparam int CNT_W     = 11;
  localparam int POS_W     = 12;
  localparam int CNT_LIMIT = 2048;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BP     = 160;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 29;

  typedef enum logic {
    TG_RESET = 1'b0,
    TG_RUN   = 1'b1
  } tg_state_e;

endpackage

// File: rtl/mouse_frame_sync.sv
// Registers raw mouse inputs every cycle and republishes them once per frame,
// generating a single click pulse on a frame-sampled rising button level.
module mouse_frame_sync
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [POS_W-1:0] xpos_in,
  input  logic [POS_W-1:0] ypos_in,
  input  logic             mouse_left_in,
  output logic [POS_W-1:0] xpos_out,
  output logic [POS_W-1:0] ypos_out,
  output logic             mouse_left_out,
  output logic             click_out
);

  logic [POS_W-1:0] xpos_raw_q, xpos_raw_d;
  logic [POS_W-1:0] ypos_raw_q, ypos_raw_d;
  logic             left_raw_q, left_raw_d;
  logic [POS_W-1:0] xpos_q, xpos_d;
  logic [POS_W-1:0] ypos_q, ypos_d;
  logic             left_q, left_d;
  logic             click_q, click_d;

  always_comb begin
    xpos_raw_d = xpos_in;
    ypos_raw_d = ypos_in;
    left_raw_d = mouse_left_in;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    left_d     = left_q;
    click_d    = 1'b0;
    // left_q still holds the previous frame's level when load is high
    if (load) begin
      xpos_d  = xpos_raw_q;
      ypos_d  = ypos_raw_q;
      left_d  = left_raw_q;
      click_d = left_raw_q & ~left_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      xpos_raw_q <= '0;
      ypos_raw_q <= '0;
      left_raw_q <= 1'b0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      left_q     <= 1'b0;
      click_q    <= 1'b0;
    end else begin
      xpos_raw_q <= xpos_raw_d;
      ypos_raw_q <= ypos_raw_d;
      left_raw_q <= left_raw_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      left_q     <= left_d;
      click_q    <= click_d;
    end
  end

  assign xpos_out       = xpos_q;
  assign ypos_out       = ypos_q;
  assign mouse_left_out = left_q;
  assign click_out      = click_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered, zero-skew sync and
// blank decode, plus frame-synchronous mouse state republishing.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        mouse_left_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_start,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        mouse_left_out,
  output logic        click_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
  end

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLNK_BEG = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_BLNK_BEG = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  tg_state_e        state_q, state_d;
  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vsync_q, vsync_d;
  logic             vblnk_q, vblnk_d;
  logic             frame_start_q, frame_start_d;

  // Decode works on the next counter values so every output lands on the
  // same edge as the counters; TG_RESET makes the first running cycle (0,0).
  always_comb begin
    state_d  = state_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (state_q == TG_RESET) begin
      state_d  = TG_RUN;
      hcount_d = '0;
      vcount_d = '0;
    end else if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
    end else begin
      hcount_d = hcount_q + CNT_W'(1);
    end
    hblnk_d       = (hcount_d >= H_BLNK_BEG);
    hsync_d       = (hcount_d >= H_SYNC_BEG) && (hcount_d <= H_SYNC_END);
    vblnk_d       = (vcount_d >= V_BLNK_BEG);
    vsync_d       = (vcount_d >= V_SYNC_BEG) && (vcount_d <= V_SYNC_END);
    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= TG_RESET;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      hblnk_q       <= hblnk_d;
      vsync_q       <= vsync_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount_out  = hcount_q;
  assign vcount_out  = vcount_q;
  assign hsync_out   = hsync_q;
  assign hblnk_out   = hblnk_q;
  assign vsync_out   = vsync_q;
  assign vblnk_out   = vblnk_q;
  assign frame_start = frame_start_q;

  mouse_frame_sync u_mouse_frame_sync (
    .clk            (clk),
    .rst            (rst),
    .load           (frame_start_d),
    .xpos_in        (xpos_in),
    .ypos_in        (ypos_in),
    .mouse_left_in  (mouse_left_in),
    .xpos_out       (xpos_out),
    .ypos_out       (ypos_out),
    .mouse_left_out (mouse_left_out),
    .click_out      (click_out)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced 25x13 raster
// (H: 16+2+3+4, V: 8+1+2+2) so whole frames stay short.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] xpos_in = '0;
  logic [11:0] ypos_in = '0;
  logic        mouse_left_in = 1'b0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out, frame_start;
  logic [11:0] xpos_out, ypos_out;
  logic        mouse_left_out, click_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int eh       = 0;
  int ev       = 0;
  int fs_cnt   = 0;
  int fs_last  = -1;
  int clicks   = 0;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .xpos_in        (xpos_in),
    .ypos_in        (ypos_in),
    .mouse_left_in  (mouse_left_in),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .hsync_out      (hsync_out),
    .hblnk_out      (hblnk_out),
    .vsync_out      (vsync_out),
    .vblnk_out      (vblnk_out),
    .frame_start    (frame_start),
    .xpos_out       (xpos_out),
    .ypos_out       (ypos_out),
    .mouse_left_out (mouse_left_out),
    .click_out      (click_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Hand-derived windows: hblnk h>=16, hsync h in 18..20, vblnk v>=8, vsync v in 9..10.
  task automatic check_timing();
    check("hcount", 32'(hcount_out), 32'(eh));
    check("vcount", 32'(vcount_out), 32'(ev));
    check("hblnk", 32'(hblnk_out), 32'(eh >= 16));
    check("hsync", 32'(hsync_out), 32'(eh >= 18 && eh <= 20));
    check("vblnk", 32'(vblnk_out), 32'(ev >= 8));
    check("vsync", 32'(vsync_out), 32'(ev >= 9 && ev <= 10));
    check("frame_start", 32'(frame_start), 32'(eh == 0 && ev == 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (eh == 24) begin
      eh = 0;
      ev = (ev == 12) ? 0 : ev + 1;
    end else begin
      eh++;
    end
    check_timing();
    if (frame_start === 1'b1) begin
      fs_cnt++;
      fs_last = cyc;
    end
    if (click_out === 1'b1) clicks++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h"}, 32'(hcount_out), 0);
    check({tag, "_v"}, 32'(vcount_out), 0);
    check({tag, "_sync_blank"}, 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_x"}, 32'(xpos_out), 0);
    check({tag, "_y"}, 32'(ypos_out), 0);
    check({tag, "_left"}, 32'(mouse_left_out), 0);
    check({tag, "_click"}, 32'(click_out), 0);
  endtask

  initial begin
    // Reset with nonzero mouse inputs present.
    rst = 1'b0; xpos_in = 12'd100; ypos_in = 12'd7; mouse_left_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("reset");

    // First running cycle is pixel (0,0) with frame_start.
    rst = 1'b1;
    @(posedge clk); #1;
    cyc = 0; eh = 0; ev = 0;
    check_timing();
    fs_cnt = 1; fs_last = 0;
    check("x_after_reset", 32'(xpos_out), 0);

    // Line 0 end: wrap 24 -> 0 with vcount 0 -> 1.
    run_to(24);
    check("line_end_h", 32'(hcount_out), 24);
    run_to(25);
    check("wrap_h", 32'(hcount_out), 0);
    check("wrap_v", 32'(vcount_out), 1);

    // Frame 0 mid: mouse outputs still hold the reset-time snapshot.
    run_to(100);
    check("x_hold_f0", 32'(xpos_out), 0);

    // Last pixel of frame then wrap to frame 1.
    run_to(324);
    check("frame_last_v", 32'(vcount_out), 12);
    check("frame_last_h", 32'(hcount_out), 24);
    run_to(325);
    check("fs_count_2", 32'(fs_cnt), 2);
    check("fs_second_at", 32'(fs_last), 325);
    check("x_f1", 32'(xpos_out), 100);
    check("y_f1", 32'(ypos_out), 7);

    // Mid-frame x change is invisible until the next frame_start.
    run_to(425);
    xpos_in = 12'd500;
    run_to(649);
    check("x_hold_f1", 32'(xpos_out), 100);
    check("fs_count_still_2", 32'(fs_cnt), 2);
    run_to(650);
    check("x_f2", 32'(xpos_out), 500);

    // Button held across three frame boundaries: one click at 975.
    run_to(700);
    mouse_left_in = 1'b1;
    run_to(974);
    check("no_click_before", 32'(clicks), 0);
    run_to(975);
    check("click_f3", 32'(click_out), 1);
    check("left_f3", 32'(mouse_left_out), 1);
    run_to(976);
    check("click_one_cycle", 32'(click_out), 0);
    run_to(1300);
    check("click_f4_none", 32'(click_out), 0);
    run_to(1625);
    check("click_f5_none", 32'(click_out), 0);
    check("held_clicks", 32'(clicks), 1);

    // Release, then press again: a second click.
    run_to(1675);
    mouse_left_in = 1'b0;
    run_to(1950);
    check("left_released", 32'(mouse_left_out), 0);
    run_to(2000);
    mouse_left_in = 1'b1;
    run_to(2275);
    check("click_second", 32'(click_out), 1);
    check("clicks_two", 32'(clicks), 2);

    // Short press between frame boundaries is never sampled.
    run_to(2300);
    mouse_left_in = 1'b0;
    run_to(2400);
    mouse_left_in = 1'b1;
    run_to(2405);
    mouse_left_in = 1'b0;
    run_to(2600);
    check("short_left", 32'(mouse_left_out), 0);
    check("short_clicks", 32'(clicks), 2);

    // Mid-frame reset at (h=10, v=5) with a press pending.
    run_to(2735);
    check("pre_rst_h", 32'(hcount_out), 10);
    check("pre_rst_v", 32'(vcount_out), 5);
    mouse_left_in = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst = 1'b1;
    @(posedge clk); #1;
    cyc = 0; eh = 0; ev = 0;
    check_timing();
    check("midrst_click", 32'(click_out), 0);
    check("midrst_left", 32'(mouse_left_out), 0);
    check("midrst_x", 32'(xpos_out), 0);

    // Button still held into the next frame is a real press.
    clicks = 0;
    run_to(325);
    check("post_rst_click", 32'(click_out), 1);
    check("post_rst_x", 32'(xpos_out), 500);
    mouse_left_in = 1'b0;
    run_to(330);
    check("post_rst_clicks", 32'(clicks), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
